// File: rtl/dct_quant_zigzag_ser_if.sv
// Block-in / coefficient-out bus for dct_quant_zigzag_ser; DCT_QZ_BYPASS_EN adds the qz_bypass sideband.
interface dct_quant_zigzag_ser_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 12
);
    logic                    in_valid;
    logic                    in_ready;
    logic [64*IN_W-1:0]      in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic [5:0]              out_idx;
    logic                    out_last;
`ifdef DCT_QZ_BYPASS_EN
    logic                    qz_bypass;

    modport master (output in_valid, in_data, out_ready, qz_bypass,
                    input  in_ready, out_valid, out_data, out_idx, out_last);
    modport slave  (input  in_valid, in_data, out_ready, qz_bypass,
                    output in_ready, out_valid, out_data, out_idx, out_last);
`else
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_idx, out_last);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_idx, out_last);
`endif
endinterface

// File: rtl/dct_quant_zigzag_ser.sv
// JPEG luma quantizer + zigzag serializer: 64-word block in, one coefficient/cycle out, first after 1 cycle.
// Output register stalls on !out_ready; in_ready is a pure state decode. DCT_QZ_BYPASS_EN: x>>>FRAC instead of quant.
module dct_quant_zigzag_ser #(
    parameter int IN_W    = 32,
    parameter int FRAC    = 8,
    parameter int OUT_W   = 12,
    parameter int RECIP_W = 17
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dct_quant_zigzag_ser_if.slave   bus
);
    localparam int S   = FRAC + 16;
    localparam int P_W = IN_W + RECIP_W + 1;

    localparam logic [P_W-1:0] HALF        = P_W'(64'd1 << (S - 1));
    localparam logic [P_W-1:0] SAT_POS_MAG = P_W'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic [P_W-1:0] SAT_NEG_MAG = P_W'(64'd1 << (OUT_W - 1));

    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

    localparam int QTAB [64] = '{
        16, 11, 10, 16,  24,  40,  51,  61,
        12, 12, 14, 19,  26,  58,  60,  55,
        14, 13, 16, 24,  40,  57,  69,  56,
        14, 17, 22, 29,  51,  87,  80,  62,
        18, 22, 37, 56,  68, 109, 103,  77,
        24, 35, 55, 64,  81, 104, 113,  92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103,  99};

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  r_state, w_state_nxt;
    logic [5:0]              r_k, w_k_nxt;
    logic                    w_accept, w_load;
    logic [IN_W-1:0]         r_buf [64];
    logic [RECIP_W-1:0]      w_recip_rom [64];
    logic                    w_bypass;

    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_data;
    logic [5:0]              r_out_idx;
    logic                    r_out_last;

    logic [5:0]              w_raster;
    logic [IN_W-1:0]         w_x;
    logic [RECIP_W-1:0]      w_recip;
    logic signed [P_W-1:0]   w_p;
    logic                    w_neg;
    logic [P_W-1:0]          w_mag, w_rnd;
    logic signed [OUT_W-1:0] w_q;

    // Reciprocals folded at elaboration: round(65536/Q) with no exact ties possible.
    for (genvar g = 0; g < 64; g++) begin : g_recip
        assign w_recip_rom[g] = RECIP_W'((65536 + QTAB[g] / 2) / QTAB[g]);
    end

`ifdef DCT_QZ_BYPASS_EN
    logic r_bypass;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_bypass <= 1'b0;
        else if (w_accept) r_bypass <= bus.qz_bypass;
    end
    assign w_bypass = r_bypass;
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_k_nxt     = 6'd0;
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                w_load = !r_out_valid || bus.out_ready;
                if (w_load) begin
                    w_k_nxt = r_k + 6'd1;
                    if (r_k == 6'd63) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_k     <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < 64; i++) r_buf[i] <= bus.in_data[i*IN_W +: IN_W];
        end
    end

    // Bypass reuses the quant path: recip = 2^16 makes the shift by S equal x >>> FRAC.
    always_comb begin
        w_raster = 6'(ZZ[r_k]);
        w_x      = r_buf[w_raster];
        w_recip  = w_bypass ? RECIP_W'(65536) : w_recip_rom[w_raster];
        w_p      = $signed({{(RECIP_W + 1){w_x[IN_W-1]}}, w_x}) *
                   $signed({{(IN_W + 1){1'b0}}, w_recip});
        w_neg    = w_p[P_W-1];
        w_mag    = w_neg ? P_W'(-w_p) : P_W'(w_p);
        w_rnd    = (w_mag + HALF) >> S;
        if (!w_neg)
            w_q = (w_rnd > SAT_POS_MAG) ? {1'b0, {(OUT_W - 1){1'b1}}} : $signed(w_rnd[OUT_W-1:0]);
        else
            w_q = (w_rnd > SAT_NEG_MAG) ? {1'b1, {(OUT_W - 1){1'b0}}} : -$signed(w_rnd[OUT_W-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= 6'd0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_q;
            r_out_idx   <= r_k;
            r_out_last  <= (r_k == 6'd63);
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = r_out_last;
endmodule

// File: tb/tb_dct_quant_zigzag_ser.sv
// Directed bench for dct_quant_zigzag_ser: hand-computed vectors plus a reference quantizer for random blocks.
module tb_dct_quant_zigzag_ser;
    localparam int IN_W  = 32;
    localparam int OUT_W = 12;

    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

    localparam int QL [64] = '{
        16, 11, 10, 16,  24,  40,  51,  61,
        12, 12, 14, 19,  26,  58,  60,  55,
        14, 13, 16, 24,  40,  57,  69,  56,
        14, 17, 22, 29,  51,  87,  80,  62,
        18, 22, 37, 56,  68, 109, 103,  77,
        24, 35, 55, 64,  81, 104, 113,  92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103,  99};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dct_quant_zigzag_ser_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    dct_quant_zigzag_ser #(.IN_W(IN_W), .FRAC(8), .OUT_W(OUT_W), .RECIP_W(17)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] cur [64];
    int          got [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    function automatic int model(input int raster, input logic [31:0] x);
        longint xs, p, a, q, r;
        xs = longint'($signed(x));
        r  = longint'((65536 + QL[raster] / 2) / QL[raster]);
        p  = xs * r;
        a  = (p < 0) ? -p : p;
        q  = (a + 64'sd8388608) / 64'sd16777216;
        if (p < 0) q = -q;
        if (q > 2047)  q = 2047;
        if (q < -2048) q = -2048;
        return int'(q);
    endfunction

    task automatic clear_cur();
        for (int i = 0; i < 64; i++) cur[i] = 32'd0;
    endtask

    task automatic rand_cur();
        for (int i = 0; i < 64; i++) begin
            cur[i] = 32'($urandom_range(0, 4194304)) - 32'd2097152;
            if (i % 16 == 5) cur[i] = $urandom();
        end
    endtask

    task automatic load_packed();
        for (int i = 0; i < 64; i++) bus.in_data[i*IN_W +: IN_W] = cur[i];
    endtask

    // Sends cur[], then consumes coefficients until stop_at have been handshaken.
    task automatic run_block(input bit rnd, input int stop_at, input string tag);
        int          cyc, k, wait_n, first_v;
        bit          stalled;
        logic [31:0] prev_d;
        logic [5:0]  prev_i;
        load_packed();
        bus.in_valid = 1'b1;
        wait_n = 0;
        while (!bus.in_ready && wait_n < 300) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        k = 0; cyc = 0; stalled = 1'b0; first_v = -1;
        prev_d = '0; prev_i = '0;
        while (k < stop_at && cyc < 2000) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid && first_v < 0) first_v = cyc;
            if (stalled) begin
                check({tag, " hold_valid"}, 32'(bus.out_valid), 32'd1);
                check({tag, " hold_data"}, 32'(bus.out_data), prev_d);
                check({tag, " hold_idx"}, 32'(bus.out_idx), 32'(prev_i));
            end
            if (bus.out_valid) begin
                if (bus.out_idx != 6'd63) check({tag, " in_ready_stream"}, 32'(bus.in_ready), 32'd0);
                if (bus.out_ready) begin
                    check({tag, " idx"}, 32'(bus.out_idx), 32'(k));
                    check({tag, " data"}, 32'(bus.out_data), 32'(model(ZZ[k], cur[ZZ[k]])));
                    check({tag, " last"}, 32'(bus.out_last), 32'(k == 63));
                    got[k] = int'(bus.out_data);
                    k++;
                end
                stalled = !bus.out_ready;
                prev_d  = 32'(bus.out_data);
                prev_i  = bus.out_idx;
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " count"}, 32'(k), 32'(stop_at));
        check({tag, " latency"}, 32'(first_v), 32'd1);
    endtask

    initial begin
        int n_acc, n_hs, e, first_acc, last_edge, kk;
        bit pend_bubble, pend_start, acc, hs;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
`ifdef DCT_QZ_BYPASS_EN
        bus.qz_bypass = 1'b0;
`endif
        #1;
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_data", 32'(bus.out_data), 32'd0);
        check("rst out_idx", 32'(bus.out_idx), 32'd0);
        check("rst out_last", 32'(bus.out_last), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // DC only: 128.0 / 16 = 8
        clear_cur();
        cur[0] = 32'h0000_8000;
        run_block(1'b0, 64, "dc");
        check("dc k0", 32'(got[0]), 32'd8);
        for (int i = 1; i < 64; i++) check("dc ac_zero", 32'(got[i]), 32'd0);

        // Rounding at raster 1 (Q=11)
        clear_cur(); cur[1] = 32'h0000_0580;
        run_block(1'b0, 64, "rnd_pos");
        check("rnd 5.5", 32'(got[1]), 32'd1);
        clear_cur(); cur[1] = 32'hFFFF_FA80;
        run_block(1'b0, 64, "rnd_neg");
        check("rnd -5.5", 32'(got[1]), 32'hFFFF_FFFF);
        clear_cur(); cur[1] = 32'h0000_0566;
        run_block(1'b0, 64, "rnd_low");
        check("rnd 5.4", 32'(got[1]), 32'd0);

        // Saturation
        clear_cur(); cur[0] = 32'h7FFF_FF00;
        run_block(1'b0, 64, "sat_pos");
        check("sat 2047", 32'(got[0]), 32'd2047);
        clear_cur(); cur[0] = 32'h8000_0000;
        run_block(1'b0, 64, "sat_neg");
        check("sat -2048", 32'(got[0]), 32'hFFFF_F800);

        // Random backpressure over 4 blocks
        for (int b = 0; b < 4; b++) begin
            rand_cur();
            run_block(1'b1, 64, "bp");
        end

        // Back-to-back: in_valid held for 3 blocks, out_ready high
        rand_cur();
        load_packed();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        n_acc = 0; n_hs = 0; e = 0; first_acc = -1; last_edge = -1;
        pend_bubble = 1'b0; pend_start = 1'b0;
        while (n_hs < 192 && e < 1000) begin
            if (pend_start) begin
                check("b2b restart_valid", 32'(bus.out_valid), 32'd1);
                check("b2b restart_idx", 32'(bus.out_idx), 32'd0);
                pend_start = 1'b0;
            end
            if (pend_bubble) begin
                check("b2b bubble", 32'(bus.out_valid), 32'd0);
                pend_bubble = 1'b0;
                if (n_hs < 192) pend_start = 1'b1;
            end
            acc = bus.in_valid && bus.in_ready;
            hs  = bus.out_valid && bus.out_ready;
            if (hs) begin
                kk = n_hs % 64;
                check("b2b idx", 32'(bus.out_idx), 32'(kk));
                check("b2b data", 32'(bus.out_data), 32'(model(ZZ[kk], cur[ZZ[kk]])));
                if (kk == 63) begin
                    pend_bubble = 1'b1;
                    last_edge   = e + 1;
                end
                n_hs++;
            end
            if (acc) begin
                n_acc++;
                if (first_acc < 0) first_acc = e + 1;
            end
            @(posedge clk); #1;
            e++;
            if (n_acc == 3) bus.in_valid = 1'b0;
        end
        check("b2b final_bubble", 32'(bus.out_valid), 32'd0);
        check("b2b handshakes", 32'(n_hs), 32'd192);
        check("b2b accepts", 32'(n_acc), 32'd3);
        check("b2b cycles", 32'(last_edge - first_acc), 32'd195);

        // Reset mid-block at k=20
        rand_cur();
        run_block(1'b0, 20, "pre_rst");
        bus.out_ready = 1'b0;
        check("pre_rst idx20", 32'(bus.out_idx), 32'd20);
        rst_n = 1'b0;
        #1;
        check("mid_rst out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst out_idx", 32'(bus.out_idx), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("post_rst idle_valid", 32'(bus.out_valid), 32'd0);
        rand_cur();
        run_block(1'b1, 64, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
